// File: rtl/btn_pkg.sv
// Types and helpers shared by the push-button conditioning logic.
// Also used by the debounce inside the watch FSM.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } btn_state_t;

    // Computed in 64 bits so that large clock rates times long delays cannot overflow.
    function automatic int ms_to_cycles(input int freq, input int ms);
        longint cycles;
        cycles = longint'(freq) / 64'sd1000 * longint'(ms);
        return int'(cycles);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pad inputs; resets to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            o_sync <= '0;
        end else begin
            r_meta <= i_async;
            o_sync <= r_meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: synchronize, debounce, one-cycle press pulse and
// optional auto-repeat pulses while held.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter bit ENABLE_REPEAT   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic button_out,
    output logic button_level,
    output logic repeating
);

    localparam int DB_CYC  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int RD_CYC  = ms_to_cycles(CLK_FREQ, REPEAT_DELAY_MS);
    localparam int RR_CYC  = ms_to_cycles(CLK_FREQ, REPEAT_RATE_MS);
    localparam int CNT_MAX = max3(DB_CYC, RD_CYC, RR_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(RR_CYC - 1);

    generate
        if (DB_CYC < 1 || RD_CYC < 1 || RR_CYC < 1) begin : g_bad_timing
            $error("button_conditioner: every derived cycle count must be at least 1");
        end
    endgenerate

    logic             w_sync;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_count;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (button_in),
        .o_sync  (w_sync)
    );

    // One shared counter times every phase; it is cleared on each state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            button_out   <= 1'b0;
            button_level <= 1'b0;
            repeating    <= 1'b0;
        end else begin
            button_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sync) begin
                        r_state <= DB_PRESS;
                        r_count <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!w_sync) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else if (r_count == DB_LAST) begin
                        r_state      <= HELD;
                        r_count      <= '0;
                        button_out   <= 1'b1;
                        button_level <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                HELD: begin
                    // Without auto-repeat the counter parks at the delay limit.
                    if (!w_sync) begin
                        r_state <= DB_RELEASE;
                        r_count <= '0;
                    end else if (r_count == RD_LAST) begin
                        if (ENABLE_REPEAT) begin
                            r_state    <= REPEAT;
                            r_count    <= '0;
                            button_out <= 1'b1;
                            repeating  <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!w_sync) begin
                        r_state   <= DB_RELEASE;
                        r_count   <= '0;
                        repeating <= 1'b0;
                    end else if (r_count == RR_LAST) begin
                        r_count    <= '0;
                        button_out <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                DB_RELEASE: begin
                    repeating <= 1'b0;
                    if (w_sync) begin
                        r_state <= HELD;
                        r_count <= '0;
                    end else if (r_count == DB_LAST) begin
                        r_state      <= IDLE;
                        r_count      <= '0;
                        button_level <= 1'b0;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: two instances (repeat on / off) share
// one input; expected pulse edges are queued per instance and popped as they occur.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic buttonIn = 1'b0;
    logic outA, levelA, repA;
    logic outB, levelB, repB;

    int checks = 0;
    int errors = 0;
    int edgeNum = 0;
    int qA[$];
    int qB[$];

    always #5 clk = ~clk;

    button_conditioner #(
        .CLK_FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
        .REPEAT_RATE_MS(3), .ENABLE_REPEAT(1'b1)
    ) dutA (
        .clk(clk), .reset(reset), .button_in(buttonIn),
        .button_out(outA), .button_level(levelA), .repeating(repA)
    );

    button_conditioner #(
        .CLK_FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
        .REPEAT_RATE_MS(3), .ENABLE_REPEAT(1'b0)
    ) dutB (
        .clk(clk), .reset(reset), .button_in(buttonIn),
        .button_out(outB), .button_level(levelB), .repeating(repB)
    );

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at edge %0d: observed %b expected %b", tag, edgeNum, obs, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, then compare both pulse outputs.
    task automatic applyStimulus(input logic val, input logic rstVal);
        logic expA, expB;
        buttonIn = val;
        reset = rstVal;
        @(posedge clk);
        #1;
        expA = (qA.size() > 0) && (qA[0] == edgeNum);
        expB = (qB.size() > 0) && (qB[0] == edgeNum);
        if (expA) void'(qA.pop_front());
        if (expB) void'(qB.pop_front());
        checkOutput("pulseA", outA, expA);
        checkOutput("pulseB", outB, expB);
        checkOutput("repeatB", repB, 1'b0);
        edgeNum++;
    endtask

    task automatic resetDut();
        checkOutput("leftoverA", logic'(qA.size() == 0), 1'b1);
        checkOutput("leftoverB", logic'(qB.size() == 0), 1'b1);
        qA.delete();
        qB.delete();
        buttonIn = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstOutA", outA, 1'b0);
        checkOutput("rstLevelA", levelA, 1'b0);
        checkOutput("rstRepA", repA, 1'b0);
        checkOutput("rstOutB", outB, 1'b0);
        checkOutput("rstLevelB", levelB, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        edgeNum = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Clean press held 8 cycles, then released.
        resetDut();
        qA.push_back(6); qB.push_back(6);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(logic'(i < 8), 1'b0);
            if (i == 5)  checkOutput("t1LevelBefore", levelA, 1'b0);
            if (i == 6)  checkOutput("t1LevelRise", levelA, 1'b1);
            if (i == 13) checkOutput("t1LevelRelDb", levelA, 1'b1);
            if (i == 14) begin
                checkOutput("t1LevelFallA", levelA, 1'b0);
                checkOutput("t1LevelFallB", levelB, 1'b0);
            end
        end

        // Press bounce: high 3, low 1, high 10.
        resetDut();
        qA.push_back(10); qB.push_back(10);
        for (int i = 0; i < 25; i++) begin
            applyStimulus(logic'((i < 3) || (i >= 4 && i < 14)), 1'b0);
            if (i == 9)  checkOutput("t2LevelBefore", levelA, 1'b0);
            if (i == 10) checkOutput("t2LevelRise", levelA, 1'b1);
            if (i == 19) checkOutput("t2LevelRelDb", levelA, 1'b1);
            if (i == 20) checkOutput("t2LevelFall", levelA, 1'b0);
        end

        // Auto-repeat while held 35 cycles; instance B must pulse only once.
        resetDut();
        foreach (qA[k]) qA.delete(k);
        for (int p = 6; p <= 34; p += 3) begin
            if (p == 6 || p >= 16) qA.push_back(p);
            if (p == 6) p = 13;
        end
        qB.push_back(6);
        for (int i = 0; i < 45; i++) begin
            applyStimulus(logic'(i < 35), 1'b0);
            if (i == 15) checkOutput("t3RepBefore", repA, 1'b0);
            if (i == 16) checkOutput("t3RepStart", repA, 1'b1);
            if (i == 36) checkOutput("t3RepHold", repA, 1'b1);
            if (i == 37) checkOutput("t3RepEnd", repA, 1'b0);
            if (i == 40) checkOutput("t3LevelRelDb", levelA, 1'b1);
            if (i == 41) begin
                checkOutput("t3LevelFallA", levelA, 1'b0);
                checkOutput("t3LevelFallB", levelB, 1'b0);
            end
        end

        // Release glitch: low for 2 cycles after edge 12, then held again.
        resetDut();
        qA.push_back(6); qA.push_back(27); qA.push_back(30);
        qB.push_back(6);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(logic'((i <= 12) || (i >= 15 && i <= 28)), 1'b0);
            if (i >= 7 && i <= 34) checkOutput("t5LevelHeld", levelA, 1'b1);
            if (i == 35) checkOutput("t5LevelFall", levelA, 1'b0);
            if (i == 26) checkOutput("t5RepBefore", repA, 1'b0);
            if (i == 27) checkOutput("t5RepStart", repA, 1'b1);
            if (i == 31) checkOutput("t5RepEnd", repA, 1'b0);
        end

        // Reset mid-repeat with the button held, then a fresh press.
        resetDut();
        qA.push_back(6); qA.push_back(16); qA.push_back(19);
        qB.push_back(6);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("t6RepBeforeRst", repA, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("t6AsyncOutA", outA, 1'b0);
        checkOutput("t6AsyncLevelA", levelA, 1'b0);
        checkOutput("t6AsyncRepA", repA, 1'b0);
        checkOutput("t6AsyncLevelB", levelB, 1'b0);
        qA.push_back(30); qB.push_back(30);
        for (int i = 20; i < 24; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 24; i < 46; i++) begin
            applyStimulus(logic'(i < 36), 1'b0);
            if (i == 29) checkOutput("t6LevelBefore", levelA, 1'b0);
            if (i == 30) checkOutput("t6LevelRise", levelA, 1'b1);
            if (i == 42) checkOutput("t6LevelFall", levelA, 1'b0);
        end

        checkOutput("finalLeftoverA", logic'(qA.size() == 0), 1'b1);
        checkOutput("finalLeftoverB", logic'(qB.size() == 0), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
